// File: rtl/clk_gate_ctrl_pkg.sv
// Shared state encoding and default timing parameters for the clock-gate enable controller.
// Optional statistics are enabled with the CLK_GATE_CTRL_STATS_EN macro in clk_gate_ctrl.sv.

package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAKE  = 2'd1,
        GATED = 2'd2
    } clk_gate_ctrl_state_e;

    localparam int unsigned IDLE_CYCLES_DEF = 16;
    localparam int unsigned WAKE_CYCLES_DEF = 2;
    localparam int unsigned STAT_W_DEF      = 32;

endpackage : clk_gate_ctrl_pkg

// File: rtl/clk_gate_ctrl.sv
// Enable generator for a downstream clk_gate cell: gates after a run of idle cycles, wakes on request.
// Define CLK_GATE_CTRL_STATS_EN to add the saturating gated_cycles_o counter.

module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int unsigned STAT_W      = STAT_W_DEF
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              busy_i,
    input  logic              wake_req_i,
    output logic              clk_en_o,
    output logic              gated_o,
`ifdef CLK_GATE_CTRL_STATS_EN
    output logic [STAT_W-1:0] gated_cycles_o,
`endif
    output logic              wake_ack_o
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || STAT_W < 1) begin : g_param_check
        $error("clk_gate_ctrl: IDLE_CYCLES, WAKE_CYCLES and STAT_W must all be >= 1");
    end

    clk_gate_ctrl_state_e state_q, state_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0]    wake_cnt_q, wake_cnt_d;
    logic                 clk_en_q, clk_en_d;
    logic                 gated_q, gated_d;
    logic                 wake_ack_q, wake_ack_d;
    logic                 idle;

    assign idle = !busy_i && !wake_req_i;

    // Outputs are computed one cycle ahead and registered, so nothing combinational reaches a port.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        clk_en_d   = clk_en_q;
        gated_d    = gated_q;
        wake_ack_d = 1'b0;

        unique case (state_q)
            RUN: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                if (wake_req_i && !wake_ack_q) begin
                    // A request while running wins over a coincident idle threshold hit.
                    wake_ack_d = 1'b1;
                    idle_cnt_d = '0;
                end else if (idle) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = GATED;
                        idle_cnt_d = '0;
                        clk_en_d   = 1'b0;
                        gated_d    = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            GATED: begin
                clk_en_d = 1'b0;
                gated_d  = 1'b1;
                if (wake_req_i) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                    clk_en_d   = 1'b1;
                    gated_d    = 1'b0;
                end
            end

            WAKE: begin
                clk_en_d = 1'b1;
                gated_d  = 1'b0;
                // Settling is not abortable: the ack goes out even if the request was withdrawn.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                    idle_cnt_d = '0;
                    wake_ack_d = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end

            default: begin
                state_d    = RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
                clk_en_d   = 1'b1;
                gated_d    = 1'b0;
            end
        endcase
    end

    // Reset forces the enable high at once so the gated domain always sees a running clock.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
            gated_q    <= gated_d;
            wake_ack_q <= wake_ack_d;
        end
    end

    assign clk_en_o   = clk_en_q;
    assign gated_o    = gated_q;
    assign wake_ack_o = wake_ack_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [STAT_W-1:0] gated_cycles_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            gated_cycles_q <= '0;
        end else if (state_q == GATED && gated_cycles_q != '1) begin
            gated_cycles_q <= gated_cycles_q + STAT_W'(1);
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`endif

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// Directed scoreboard bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Define CLK_GATE_CTRL_STATS_EN to also exercise gated_cycles_o.

module tb_clk_gate_ctrl;

    localparam int unsigned STAT_W = 32;

    typedef struct {
        logic [2:0] outs;
        string      tag;
    } exp_t;

    logic              clk;
    logic              arst_n;
    logic              busy;
    logic              wake_req;
    logic              clk_en;
    logic              gated;
    logic              wake_ack;
    logic [STAT_W-1:0] gated_cycles;

    int unsigned compared;
    int unsigned mismatched;
    exp_t        exp_q[$];

    clk_gate_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2),
        .STAT_W     (STAT_W)
    ) dut (
        .clk_i         (clk),
        .arst_ni       (arst_n),
        .busy_i        (busy),
        .wake_req_i    (wake_req),
        .clk_en_o      (clk_en),
        .gated_o       (gated),
`ifdef CLK_GATE_CTRL_STATS_EN
        .gated_cycles_o(gated_cycles),
`endif
        .wake_ack_o    (wake_ack)
    );

`ifndef CLK_GATE_CTRL_STATS_EN
    assign gated_cycles = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pops the oldest expectation and compares it with {clk_en, gated, wake_ack}.
    task automatic checkOutput();
        exp_t e;
        logic [2:0] obs;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: observed nothing queued, required one entry");
            return;
        end
        e   = exp_q.pop_front();
        obs = {clk_en, gated, wake_ack};
        compared++;
        assert (obs === e.outs)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed en/gated/ack=%b required %b", e.tag, obs, e.outs);
        end
    endtask

    // Drives one cycle of inputs after the falling edge and checks the registered result.
    task automatic applyStimulus(input logic b, input logic r, input logic [2:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        busy     = b;
        wake_req = r;
        e.outs   = exp;
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkNow(input string tag, input logic [2:0] exp);
        exp_t e;
        e.outs = exp;
        e.tag  = tag;
        exp_q.push_back(e);
        checkOutput();
    endtask

    task automatic checkStat(input string tag, input logic [STAT_W-1:0] exp);
        compared++;
        assert (gated_cycles === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed gated_cycles=%0d required %0d", tag, gated_cycles, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        busy       = 1'b1;
        wake_req   = 1'b0;
        arst_n     = 1'b1;

        // Reset asserted mid-cycle must take effect without a clock edge.
        #12;
        arst_n = 1'b0;
        #1;
        checkNow("reset_async", 3'b100);
        @(negedge clk);
        arst_n = 1'b1;
        $display("[TB] reset released");

        // Idle entry: gating after the fourth idle edge; busy ignored while gated.
        applyStimulus(1'b0, 1'b0, 3'b100, "idle_e1");
        applyStimulus(1'b0, 1'b0, 3'b100, "idle_e2");
        applyStimulus(1'b0, 1'b0, 3'b100, "idle_e3");
        applyStimulus(1'b0, 1'b0, 3'b010, "idle_e4_gate");
        applyStimulus(1'b1, 1'b0, 3'b010, "gated_busy_ignored");

        // Wake from gated: enable next edge, ack two edges later for one cycle.
        applyStimulus(1'b0, 1'b1, 3'b100, "wake_k");
        applyStimulus(1'b0, 1'b1, 3'b100, "wake_k1");
        applyStimulus(1'b0, 1'b1, 3'b101, "wake_k2_ack");
        applyStimulus(1'b0, 1'b1, 3'b100, "wake_no_double_ack");
        applyStimulus(1'b1, 1'b0, 3'b100, "run_busy");

        // Idle restart: busy on the third idle edge restarts the count.
        applyStimulus(1'b0, 1'b0, 3'b100, "restart_i1");
        applyStimulus(1'b0, 1'b0, 3'b100, "restart_i2");
        applyStimulus(1'b1, 1'b0, 3'b100, "restart_busy");
        applyStimulus(1'b0, 1'b0, 3'b100, "restart_j1");
        applyStimulus(1'b0, 1'b0, 3'b100, "restart_j2");
        applyStimulus(1'b0, 1'b0, 3'b100, "restart_j3");
        applyStimulus(1'b0, 1'b0, 3'b010, "restart_j4_gate");

        // Request withdrawn during WAKE still completes with an ack.
        applyStimulus(1'b0, 1'b1, 3'b100, "early_drop_wake");
        applyStimulus(1'b0, 1'b0, 3'b100, "early_drop_settle");
        applyStimulus(1'b0, 1'b0, 3'b101, "early_drop_ack");
        applyStimulus(1'b0, 1'b0, 3'b100, "early_drop_after");

        // Wake in RUN at idle_cnt=3 beats the threshold; held request gets no second ack.
        applyStimulus(1'b1, 1'b0, 3'b100, "runwake_busy");
        applyStimulus(1'b0, 1'b0, 3'b100, "runwake_i1");
        applyStimulus(1'b0, 1'b0, 3'b100, "runwake_i2");
        applyStimulus(1'b0, 1'b0, 3'b100, "runwake_i3");
        applyStimulus(1'b0, 1'b1, 3'b101, "runwake_ack");
        applyStimulus(1'b0, 1'b1, 3'b100, "runwake_held");
        applyStimulus(1'b1, 1'b0, 3'b100, "runwake_release");

        // Reset during WAKE at wake_cnt=1: no ack, back in RUN.
        applyStimulus(1'b0, 1'b0, 3'b100, "rstwake_i1");
        applyStimulus(1'b0, 1'b0, 3'b100, "rstwake_i2");
        applyStimulus(1'b0, 1'b0, 3'b100, "rstwake_i3");
        applyStimulus(1'b0, 1'b0, 3'b010, "rstwake_gate");
        applyStimulus(1'b0, 1'b1, 3'b100, "rstwake_wake");
        applyStimulus(1'b0, 1'b1, 3'b100, "rstwake_cnt1");
        arst_n = 1'b0;
        #1;
        checkNow("rstwake_async", 3'b100);
        @(posedge clk);
        #1;
        checkNow("rstwake_no_ack", 3'b100);
        @(negedge clk);
        busy     = 1'b1;
        wake_req = 1'b0;
        arst_n   = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b100, "rstwake_run");

`ifdef CLK_GATE_CTRL_STATS_EN
        checkStat("stat_after_reset", '0);
`endif

        // Ten edges spent in GATED after the gating edge.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'b100, "stat_idle");
        applyStimulus(1'b0, 1'b0, 3'b010, "stat_gate");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 3'b010, "stat_gated");

`ifdef CLK_GATE_CTRL_STATS_EN
        checkStat("stat_ten_cycles", STAT_W'(10));
`endif

        applyStimulus(1'b0, 1'b1, 3'b100, "final_wake");
        applyStimulus(1'b0, 1'b1, 3'b100, "final_settle");
        applyStimulus(1'b0, 1'b1, 3'b101, "final_ack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_clk_gate_ctrl
